demux_cmd_seq: RTL and testbench

DEMUX_CMD_SEQ -- requirements
Module: demux_cmd_seq

---
 rtl/demux_seq_pkg.sv | 17 +
 rtl/cmd_fifo.sv | 53 +++++
 rtl/demux_cmd_seq.sv | 116 +++++++++++
 tb/tb_demux_cmd_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_seq_pkg.sv
// Shared types for the command-driven 1-to-8 demux sequencer.
package demux_seq_pkg;

  localparam int CH_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [CH_W-1:0] addr;
    logic            data;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; level distinguishes full from empty so pointers wrap freely.
module cmd_fifo
  import demux_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  cmd_t             wr_cmd,
  output cmd_t             rd_cmd,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_cmd  = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_cmd;
  end

endmodule

// File: rtl/demux_cmd_seq.sv
// Pops queued {addr,data} commands and drives sel/din to a downstream demux for HOLD cycles each.
module demux_cmd_seq
  import demux_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd_addr,
  input  logic                         cmd_data,
  output logic [2:0]                   sel,
  output logic                         din,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int CMAX  = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W = $clog2(CMAX + 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CH_W-1:0]  sel_nx;
  logic             din_nx;
  logic             pop;
  logic             push;
  logic             rdy_en;
  logic             full;
  logic             empty;
  cmd_t             head;

  assign cmd_ready = rdy_en && !full;
  assign push      = cmd_valid && cmd_ready;
  assign done      = (state == ST_DRIVE) && (cnt == '0);
  assign busy      = (state != ST_IDLE) || !empty;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wr_cmd ('{addr: cmd_addr, data: cmd_data}),
    .rd_cmd (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sel_nx   = sel;
    din_nx   = din;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        din_nx = 1'b0;
        if (!empty) begin
          pop      = 1'b1;
          sel_nx   = head.addr;
          din_nx   = head.data;
          cnt_nx   = CNT_W'(HOLD - 1);
          state_nx = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (GAP > 0) begin
          din_nx   = 1'b0;
          cnt_nx   = CNT_W'(GAP - 1);
          state_nx = ST_GAP;
        end else if (!empty) begin
          // Back-to-back: next command loads on the edge that ends this one.
          pop    = 1'b1;
          sel_nx = head.addr;
          din_nx = head.data;
          cnt_nx = CNT_W'(HOLD - 1);
        end else begin
          din_nx   = 1'b0;
          state_nx = ST_IDLE;
        end
      end
      ST_GAP: begin
        din_nx = 1'b0;
        if (cnt != '0) cnt_nx = cnt - 1'b1;
        else           state_nx = ST_IDLE;
      end
      default: begin
        din_nx   = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sel    <= '0;
      din    <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sel    <= sel_nx;
      din    <= din_nx;
      rdy_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_demux_cmd_seq.sv
// Directed bench for demux_cmd_seq: one GAP=1 instance and one GAP=0 instance.
module tb_demux_cmd_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_data, cmd_ready, din, busy, done;
  logic [2:0] cmd_addr, sel, level;
  logic       cmd_valid_g0, cmd_data_g0, cmd_ready_g0, din_g0, busy_g0, done_g0;
  logic [2:0] cmd_addr_g0, sel_g0, level_g0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  demux_cmd_seq #(.DEPTH(4), .HOLD(2), .GAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .sel(sel), .din(din),
    .busy(busy), .done(done), .level(level)
  );

  demux_cmd_seq #(.DEPTH(4), .HOLD(2), .GAP(0)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_g0), .cmd_ready(cmd_ready_g0),
    .cmd_addr(cmd_addr_g0), .cmd_data(cmd_data_g0), .sel(sel_g0), .din(din_g0),
    .busy(busy_g0), .done(done_g0), .level(level_g0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      step;
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    int idx, got, bad_rdy, bad_lvl, saw_full, saw_simul, leaked;
    logic rdy_prev;
    logic [2:0] lvl_prev;

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_data = 1'b0;
    cmd_valid_g0 = 1'b0; cmd_addr_g0 = '0; cmd_data_g0 = 1'b0;
    step; step;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_din", din, 0);
    chk("rst_sel", sel, 0);
    chk("rst_done", done, 0);
    chk("rst_ready_g0", cmd_ready_g0, 0);
    #2 rst_n = 1'b1;
    step;
    chk("ready_after_release", cmd_ready, 1);
    chk("ready_after_release_g0", cmd_ready_g0, 1);

    // GAP=0 back-to-back: addr 3 then 6
    cmd_valid_g0 = 1'b1; cmd_addr_g0 = 3'd3; cmd_data_g0 = 1'b1;
    step;
    cmd_addr_g0 = 3'd6;
    step;
    cmd_valid_g0 = 1'b0;
    chk("b2b_sel_a", sel_g0, 3);
    chk("b2b_din_a", din_g0, 1);
    chk("b2b_done_a0", done_g0, 0);
    step;
    chk("b2b_done_a1", done_g0, 1);
    chk("b2b_sel_a1", sel_g0, 3);
    step;
    chk("b2b_sel_b", sel_g0, 6);
    chk("b2b_din_b", din_g0, 1);
    chk("b2b_done_b0", done_g0, 0);
    chk("b2b_level", level_g0, 0);
    step;
    chk("b2b_done_b1", done_g0, 1);
    step;
    chk("b2b_din_idle", din_g0, 0);
    chk("b2b_busy_idle", busy_g0, 0);
    chk("b2b_sel_hold", sel_g0, 6);

    // Single command addr=5 data=1
    cmd_valid = 1'b1; cmd_addr = 3'd5; cmd_data = 1'b1;
    step;
    cmd_valid = 1'b0;
    chk("one_level", level, 1);
    chk("one_busy", busy, 1);
    chk("one_din_pre", din, 0);
    step;
    chk("one_sel", sel, 5);
    chk("one_din1", din, 1);
    chk("one_done1", done, 0);
    chk("one_level0", level, 0);
    step;
    chk("one_din2", din, 1);
    chk("one_done2", done, 1);
    step;
    chk("one_gap_din", din, 0);
    chk("one_gap_sel", sel, 5);
    chk("one_gap_done", done, 0);
    chk("one_gap_busy", busy, 1);
    step;
    chk("one_idle_busy", busy, 0);
    chk("one_idle_din", din, 0);

    // Data=0 command still completes with a done pulse
    cmd_valid = 1'b1; cmd_addr = 3'd2; cmd_data = 1'b0;
    step;
    cmd_valid = 1'b0;
    step;
    chk("zero_sel", sel, 2);
    chk("zero_din1", din, 0);
    chk("zero_done1", done, 0);
    step;
    chk("zero_done2", done, 1);
    chk("zero_din2", din, 0);
    step;
    chk("zero_done3", done, 0);
    step;
    chk("zero_idle", busy, 0);

    // Eight commands at full rate
    idx = 0; got = 0; bad_rdy = 0; saw_full = 0; saw_simul = 0;
    rdy_prev = cmd_ready; lvl_prev = level;
    cmd_valid = 1'b1; cmd_addr = 3'd0; cmd_data = 1'b1;
    for (int c = 0; c < 150 && got < 8; c++) begin
      step;
      if (cmd_valid && rdy_prev) begin
        if (level == lvl_prev) saw_simul = 1;
        idx++;
      end
      if (level == 3'd4) begin
        saw_full = 1;
        if (cmd_ready) bad_rdy++;
      end
      if (done) begin
        chk("burst_order", sel, got);
        chk("burst_din", din, 1);
        got++;
      end
      rdy_prev = cmd_ready;
      lvl_prev = level;
      cmd_valid = (idx < 8);
      cmd_addr = idx[2:0];
    end
    cmd_valid = 1'b0;
    chk("burst_count", got, 8);
    chk("burst_saw_full", saw_full, 1);
    chk("burst_ready_when_full", bad_rdy, 0);
    chk("burst_push_pop_same_edge", saw_simul, 1);
    wait_idle("burst_idle");

    // Keep the FIFO topped up while draining
    bad_rdy = 0; bad_lvl = 0;
    cmd_valid = 1'b1; cmd_data = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cmd_addr = c[2:0];
      step;
      if (c >= 6 && (level < 3'd3 || level > 3'd4)) bad_lvl++;
      if (level == 3'd4 && cmd_ready) bad_rdy++;
    end
    cmd_valid = 1'b0;
    chk("sustain_level", bad_lvl, 0);
    chk("sustain_ready_full", bad_rdy, 0);
    wait_idle("sustain_idle");

    // Reset while driving with three commands queued
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_addr = 3'(i + 1); cmd_data = 1'b1;
      step;
    end
    cmd_valid = 1'b0;
    step;
    chk("mid_sel", sel, 2);
    chk("mid_din", din, 1);
    chk("mid_level", level, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_din", din, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_sel", sel, 0);
    step; step;
    rst_n = 1'b1;
    leaked = 0;
    for (int c = 0; c < 10; c++) begin
      step;
      if (din || busy) leaked++;
    end
    chk("post_rst_nothing_driven", leaked, 0);
    chk("post_rst_ready", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
